merge_ctrl: RTL and testbench
=============================

# merge_ctrl

Two-way merge sequencer for the parallel merge-sort datapath. Pops two ascending sorted runs of equal length from two input sync FIFOs, using their peek heads (`dcmp`) and `rd_en`/`empty` handshakes, and writes the merged ascending stream into an output FIFO. Each merge pass is started by a pulse and ends with a one-cycle `done` pulse. Instances are chained per merge level in the sort tree.

## Interface
- `DATA_WIDTH`, 32, key width. Keys compare as unsigned.
- `LOG2_RUN`, 4, run-length counter sizing. `run_len` and internal counters are `LOG2_RUN+1` bits wide.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `start` in 1: begin a pass. Sampled only in IDLE.
- `run_len` in LOG2_RUN+1: elements per input run. Latched on an accepted `start`.
- `a_head` in DATA_WIDTH: head of FIFO A (its `dcmp`).
- `a_empty` in 1: FIFO A empty.
- `rd_en_a` out 1: pop FIFO A this cycle.
- `b_head` in DATA_WIDTH: head of FIFO B.
- `b_empty` in 1: FIFO B empty.
- `rd_en_b` out 1: pop FIFO B this cycle.
- `out_full` in 1: output FIFO full.
- `out_wr_en` out 1: write to the output FIFO this cycle.
- `out_data` out DATA_WIDTH: write data. 0 when `out_wr_en`=0.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pass-complete pulse.

## Operation
- Registers: `state`, `len_q`, `cnt_a`, `cnt_b` (counts of elements popped from A and B). Counters are LOG2_RUN+1 bits, so any `run_len` value is counted exactly and no wrap is possible.
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, DONE.
- IDLE: on `start`, latch `len_q`=`run_len` and clear the counters. If `run_len`=0, go to DONE; otherwise go to MERGE. `start` is ignored in all other states.
- MERGE issues only when `!a_empty && !b_empty && !out_full`.
  - Pick A if `a_head <= b_head`, otherwise pick B. Ties go to A, so the merge is stable.
  - On issue, assert the chosen `rd_en_x` and `out_wr_en`, drive `out_data` = the chosen head, and increment that counter. All three outputs are combinational in the same cycle.
  - If the issue condition is not met, stall with all outputs low.
- MERGE exits, evaluated on post-increment counts:
  - `cnt_a`==`len_q` → DRAIN_B.
  - `cnt_b`==`len_q` → DRAIN_A.
  - Both can never be reached in the same cycle, because only one pop happens per cycle.
- DRAIN_A: issue from A whenever `!a_empty && !out_full`. `b_empty` and `b_head` are ignored. When `cnt_a` reaches `len_q`, go to DONE. DRAIN_B is symmetric.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. No pops occur.
- There is never more than one `rd_en` per cycle. `rd_en_x` is never asserted while `x_empty`=1, and `out_wr_en` is never asserted while `out_full`=1.
- Reset (asynchronous, at any time including mid-pass): state=IDLE, counters=0, `len_q`=0.
  - All outputs go to 0 immediately: `rd_en_a`, `rd_en_b`, `out_wr_en`, `out_data`, `busy`, `done`.
  - Partially consumed FIFO contents are not restored; upstream logic must reset the FIFOs together with this block.

## Timing
- `start` is accepted at edge N. From cycle N+1, `busy`=1 and the first pop is possible.
- Throughput is one element per cycle when unstalled. A pass of two runs of length L completes 2L writes in 2L cycles minimum.
- Pop-to-write latency is 0: the pop and the write happen on the same edge.
- `done` is high in the cycle after the final write. `busy` falls in the cycle after `done`.
- With `run_len`=0: `done` is high in cycle N+1, and `busy` is high in cycle N+1 only.
- `start` asserted during the DONE cycle is ignored. A new pass can start in the IDLE cycle that follows.

## Test plan
- Basic merge: A={1,4,7,9}, B={2,3,8,10}, `run_len`=4, all FIFOs ready → `out_data` 1,2,3,4,7,8,9,10 on 8 consecutive cycles; `done` in cycle 9 after start; `rd_en_a` and `rd_en_b` each pulse 4 times.
- Ties and drain: A={5,5,6}, B={5,9,9}, `run_len`=3 → output 5(A),5(A),5(B),6(A), then DRAIN_B writes 9,9; `done` follows.
- Stalls: B is empty for 3 cycles mid-merge, then `out_full`=1 for 2 cycles → no `rd_en` and no `out_wr_en` during the stalls; data order is unchanged and the total write count is 2×`run_len`.
- Zero length: `start` with `run_len`=0 → no pops, `done` 1 cycle later, `busy` high for 1 cycle.
- Mid-pass reset: assert `reset` asynchronously after 3 writes → all outputs 0 immediately without waiting for a clock edge. After release and a new `start` with fresh FIFOs, the full pass completes correctly.
- Start while busy: pulse `start` with `run_len`=2 during MERGE → ignored; the current pass completes with its original length.

Source files
------------

// File: rtl/merge_if.sv
// merge_if: handshake bundle between a merge sequencer and its surroundings.
// Carries the pass control (start/run_len/busy/done), the peek/pop ports of
// the two input FIFOs and the write port of the output FIFO.
interface merge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_RUN   = 4
);
    // Pass control
    logic                  start;
    logic [LOG2_RUN:0]     run_len;
    logic                  busy;
    logic                  done;

    // Input FIFO A (peek head + pop)
    logic [DATA_WIDTH-1:0] a_head;
    logic                  a_empty;
    logic                  rd_en_a;

    // Input FIFO B (peek head + pop)
    logic [DATA_WIDTH-1:0] b_head;
    logic                  b_empty;
    logic                  rd_en_b;

    // Output FIFO write port
    logic                  out_full;
    logic                  out_wr_en;
    logic [DATA_WIDTH-1:0] out_data;

    // The merge sequencer side
    modport slave (
        input  start, run_len,
        input  a_head, a_empty,
        input  b_head, b_empty,
        input  out_full,
        output rd_en_a, rd_en_b,
        output out_wr_en, out_data,
        output busy, done
    );

    // The environment side: pass controller plus the three FIFOs
    modport master (
        output start, run_len,
        output a_head, a_empty,
        output b_head, b_empty,
        output out_full,
        input  rd_en_a, rd_en_b,
        input  out_wr_en, out_data,
        input  busy, done
    );
endinterface

// File: rtl/merge_ctrl.sv
// merge_ctrl: two-way merge sequencer for one level of the merge-sort tree.
// Pops two ascending runs of equal length from FIFOs A and B and writes the
// merged ascending stream to the output FIFO, one element per cycle when
// nothing stalls. Pops and the matching write happen on the same edge, so
// the pop/write strobes and write data are decoded combinationally from the
// current state and the FIFO flags; busy/done are plain registers.
module merge_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_RUN   = 4
) (
    input  logic   clk,
    input  logic   reset,
    merge_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MERGE   = 3'd1,
        ST_DRAIN_A = 3'd2,
        ST_DRAIN_B = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int CW = LOG2_RUN + 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;
    logic            busy_q;
    logic            done_q;

    logic            issue_a;
    logic            issue_b;
    logic            pick_a;
    logic            start_ok;

    // A pass may only begin from IDLE; start is ignored anywhere else.
    assign start_ok = (state_q == ST_IDLE) && bus.start;

    // Ties go to A so that equal keys keep their A-before-B order.
    assign pick_a = (bus.a_head <= bus.b_head);

    // Decide which FIFO (if any) pops this cycle.
    always_comb begin
        issue_a = 1'b0;
        issue_b = 1'b0;
        case (state_q)
            ST_MERGE: begin
                // Both heads must be valid to compare, and there must be room.
                if (!bus.a_empty && !bus.b_empty && !bus.out_full) begin
                    issue_a = pick_a;
                    issue_b = !pick_a;
                end
            end
            ST_DRAIN_A: issue_a = !bus.a_empty && !bus.out_full;
            ST_DRAIN_B: issue_b = !bus.b_empty && !bus.out_full;
            default: begin
                issue_a = 1'b0;
                issue_b = 1'b0;
            end
        endcase
    end

    // Post-pop element counts; the exit decisions look at these.
    always_comb begin
        cnt_a_d = cnt_a_q + {{LOG2_RUN{1'b0}}, issue_a};
        cnt_b_d = cnt_b_q + {{LOG2_RUN{1'b0}}, issue_b};
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.run_len == '0) ? ST_DONE : ST_MERGE;
                end
            end
            ST_MERGE: begin
                // Only one pop per cycle, so at most one run can finish here.
                if (cnt_a_d == len_q) begin
                    state_d = ST_DRAIN_B;
                end else if (cnt_b_d == len_q) begin
                    state_d = ST_DRAIN_A;
                end
            end
            ST_DRAIN_A: begin
                if (cnt_a_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN_B: begin
                if (cnt_b_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, run length, pop counters and the registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (start_ok) begin
                len_q   <= bus.run_len;
                cnt_a_q <= '0;
                cnt_b_q <= '0;
            end else begin
                cnt_a_q <= cnt_a_d;
                cnt_b_q <= cnt_b_d;
            end
        end
    end

    // Pop strobes, write strobe and write data for the current cycle.
    always_comb begin
        bus.rd_en_a   = issue_a;
        bus.rd_en_b   = issue_b;
        bus.out_wr_en = issue_a | issue_b;
        if (issue_a) begin
            bus.out_data = bus.a_head;
        end else if (issue_b) begin
            bus.out_data = bus.b_head;
        end else begin
            bus.out_data = '0;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_merge_ctrl.sv
// tb_merge_ctrl: directed bench for merge_ctrl. Models the two input FIFOs and
// the output FIFO as queues, applies hand-written runs and stall windows, and
// compares the written stream and pass timing against hand-computed values.
module tb_merge_ctrl;

    localparam int DW = 32;
    localparam int LR = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    merge_if #(.DATA_WIDTH(DW), .LOG2_RUN(LR)) mif ();

    merge_ctrl #(.DATA_WIDTH(DW), .LOG2_RUN(LR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] wr_log[$];
    int          src_log[$];
    int          cyc;
    int          done_cyc;
    int          busy_cnt;
    int          n_rda;
    int          n_rdb;
    int          viol;
    int          stall_viol;
    int          hb_lo, hb_hi, hf_lo, hf_hi;
    int          sb1, sb2;
    logic        last_busy;
    logic        hold_b_now;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        wr_log.delete();
        src_log.delete();
        cyc        = 0;
        done_cyc   = -1;
        busy_cnt   = 0;
        n_rda      = 0;
        n_rdb      = 0;
        viol       = 0;
        stall_viol = 0;
        hb_lo = -1; hb_hi = -2;
        hf_lo = -1; hf_hi = -2;
        sb1   = -1; sb2   = -1;
        last_busy = 1'b0;
    endtask

    // Drive FIFO flags/heads and the stall windows for the current cycle.
    task automatic apply_inputs();
        hold_b_now   = (cyc >= hb_lo) && (cyc <= hb_hi);
        mif.a_empty  = (qa.size() == 0);
        mif.a_head   = (qa.size() > 0) ? qa[0] : '0;
        mif.b_empty  = (qb.size() == 0) || hold_b_now;
        mif.b_head   = (qb.size() > 0) ? qb[0] : '0;
        mif.out_full = (cyc >= hf_lo) && (cyc <= hf_hi);
        mif.start    = (cyc == sb1) || (cyc == sb2);
        if (mif.start) mif.run_len = 5'd2;
    endtask

    // One environment cycle: drive, sample mid-cycle, pop after the edge.
    task automatic tick();
        logic s_rda, s_rdb, s_wr, s_busy, s_done, hold;
        logic [31:0] s_data;
        @(negedge clk);
        apply_inputs();
        #1;
        s_rda  = mif.rd_en_a;
        s_rdb  = mif.rd_en_b;
        s_wr   = mif.out_wr_en;
        s_data = mif.out_data;
        s_busy = mif.busy;
        s_done = mif.done;
        hold   = mif.out_full || hold_b_now;
        if (s_rda && s_rdb) viol++;
        if (s_rda && mif.a_empty) viol++;
        if (s_rdb && mif.b_empty) viol++;
        if (s_wr && mif.out_full) viol++;
        if (s_wr != (s_rda || s_rdb)) viol++;
        if (!s_wr && s_data != 0) viol++;
        if (hold && (s_rda || s_rdb || s_wr)) stall_viol++;
        if (s_wr) begin
            wr_log.push_back(s_data);
            src_log.push_back(s_rdb ? 1 : 0);
            $display("cyc %0d write %0d from %s", cyc, s_data, s_rdb ? "B" : "A");
        end
        if (s_rda) n_rda++;
        if (s_rdb) n_rdb++;
        if (s_busy) busy_cnt++;
        if (s_done && done_cyc < 0) done_cyc = cyc;
        last_busy = s_busy;
        @(posedge clk);
        #1;
        if (s_rda && qa.size() > 0) void'(qa.pop_front());
        if (s_rdb && qb.size() > 0) void'(qb.pop_front());
        mif.start = 1'b0;
        cyc++;
    endtask

    // Present start in an IDLE cycle; the following cycle is numbered 1.
    task automatic start_pass(input logic [4:0] len);
        @(negedge clk);
        apply_inputs();
        mif.start   = 1'b1;
        mif.run_len = len;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        cyc = 1;
    endtask

    // Run until done is seen (bounded), then one more cycle to see busy drop.
    task automatic run_pass(input string tag, input int budget);
        int k;
        k = 0;
        while (done_cyc < 0 && k < budget) begin
            tick();
            k++;
        end
        tick();
        chk($sformatf("%s_busy_after_done", tag), {31'd0, last_busy}, 32'd0);
    endtask

    task automatic chk_stream(input string tag, input logic [31:0] exp[$]);
        logic [31:0] got;
        chk($sformatf("%s_nwrites", tag), wr_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < wr_log.size()) ? wr_log[i] : 32'hDEAD_BEEF;
            chk($sformatf("%s_data%0d", tag, i), got, exp[i]);
        end
    endtask

    initial begin
        logic [31:0] exp[$];
        logic [5:0]  srcbits;

        mif.start    = 1'b0;
        mif.run_len  = '0;
        mif.a_head   = '0;
        mif.a_empty  = 1'b1;
        mif.b_head   = '0;
        mif.b_empty  = 1'b1;
        mif.out_full = 1'b0;
        clear_stats();

        // Reset state
        #2;
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_done", {31'd0, mif.done}, 32'd0);
        chk("rst_wr",   {31'd0, mif.out_wr_en}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic merge
        clear_stats();
        qa = '{1, 4, 7, 9};
        qb = '{2, 3, 8, 10};
        start_pass(5'd4);
        run_pass("basic", 30);
        exp = '{1, 2, 3, 4, 7, 8, 9, 10};
        chk_stream("basic", exp);
        chk("basic_done_cyc", done_cyc, 9);
        chk("basic_rda", n_rda, 4);
        chk("basic_rdb", n_rdb, 4);
        chk("basic_busy_cycles", busy_cnt, 9);
        chk("basic_protocol", viol, 0);

        // Ties and drain
        clear_stats();
        qa = '{5, 5, 6};
        qb = '{5, 9, 9};
        start_pass(5'd3);
        run_pass("ties", 30);
        exp = '{5, 5, 5, 6, 9, 9};
        chk_stream("ties", exp);
        srcbits = '0;
        for (int i = 0; i < src_log.size() && i < 6; i++)
            srcbits = {srcbits[4:0], (src_log[i] != 0)};
        chk("ties_src_order", srcbits, 6'b001011);
        chk("ties_done_cyc", done_cyc, 7);
        chk("ties_protocol", viol, 0);

        // Stalls: B empty in cycles 3..5, output full in cycles 7..8
        clear_stats();
        qa = '{1, 4, 7, 9};
        qb = '{2, 3, 8, 10};
        hb_lo = 3; hb_hi = 5;
        hf_lo = 7; hf_hi = 8;
        start_pass(5'd4);
        run_pass("stall", 40);
        exp = '{1, 2, 3, 4, 7, 8, 9, 10};
        chk_stream("stall", exp);
        chk("stall_done_cyc", done_cyc, 14);
        chk("stall_quiet", stall_viol, 0);
        chk("stall_protocol", viol, 0);

        // Zero length
        clear_stats();
        qa = '{3};
        qb = '{4};
        start_pass(5'd0);
        run_pass("zero", 10);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_writes", wr_log.size(), 0);
        chk("zero_pops", n_rda + n_rdb, 0);
        qa.delete();
        qb.delete();

        // Mid-pass asynchronous reset after 3 writes
        clear_stats();
        qa = '{1, 4, 7, 9};
        qb = '{2, 3, 8, 10};
        start_pass(5'd4);
        repeat (3) tick();
        chk("rst_mid_writes", wr_log.size(), 3);
        @(negedge clk);
        apply_inputs();
        #1;
        chk("rst_mid_pre_wr",   {31'd0, mif.out_wr_en}, 32'd1);
        chk("rst_mid_pre_data", mif.out_data, 32'd4);
        reset = 1'b1;
        #1;
        chk("rst_mid_rda",  {31'd0, mif.rd_en_a},   32'd0);
        chk("rst_mid_rdb",  {31'd0, mif.rd_en_b},   32'd0);
        chk("rst_mid_wr",   {31'd0, mif.out_wr_en}, 32'd0);
        chk("rst_mid_data", mif.out_data,           32'd0);
        chk("rst_mid_busy", {31'd0, mif.busy},      32'd0);
        chk("rst_mid_done", {31'd0, mif.done},      32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        qa = '{1, 4, 7, 9};
        qb = '{2, 3, 8, 10};
        start_pass(5'd4);
        run_pass("rerun", 30);
        exp = '{1, 2, 3, 4, 7, 8, 9, 10};
        chk_stream("rerun", exp);
        chk("rerun_done_cyc", done_cyc, 9);

        // Start while busy (cycle 2) and during DONE (cycle 7) are ignored
        clear_stats();
        qa = '{1, 3, 5};
        qb = '{2, 4, 6};
        sb1 = 2;
        sb2 = 7;
        start_pass(5'd3);
        run_pass("busy_start", 30);
        exp = '{1, 2, 3, 4, 5, 6};
        chk_stream("busy_start", exp);
        chk("busy_start_done_cyc", done_cyc, 7);
        chk("busy_start_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
